ai_sector_loader: RTL
=====================

// Module: ai_sector_loader
// PURPOSE
//  Downstream of the comparer's Avalon-MM register block. On an init pulse, reads load_len 32-bit words of a stored
//  reference pattern from memory via an Avalon-MM pipelined read master, starting at sector load_sector.
//  Unpacks the words into signed 24-bit samples (optional 2x16-bit compression), clamps them to +/-max, and streams
//  them to the comparer core over a valid/ready interface, with last on the final sample.
// PARAMETERS
//  SECTOR_LOG2   8   log2(words per sector); sector byte offset = load_sector << (SECTOR_LOG2+2)
//  FIFO_DEPTH    8   word buffer depth (power of 2); also caps reads in flight
// PORTS
//  clk             in   1   single clock
//  rst             in   1   asynchronous, active-low reset
//  init            in   1   1-cycle start pulse
//  base_addr       in   32  byte base address of pattern memory
//  load_sector     in   16  start sector
//  load_len        in   16  number of 32-bit words to read
//  compress        in   1   1: each word = two int16 samples (low half first)
//  max             in   24  clamp magnitude; 0 = no clamp
//  avm_address     out  32  byte address, word aligned
//  avm_read        out  1   read request
//  avm_waitrequest in   1   slave stall
//  avm_readdata    in   32  read data
//  avm_readdatavalid in 1   read data valid
//  out_data        out  24  signed sample
//  out_valid       out  1   sample valid
//  out_ready       in   1   consumer accept
//  out_last        out  1   final sample of the transfer
//  busy            out  1   high from init accept to done
//  done            out  1   1-cycle pulse at completion
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, counters 0, state IDLE. Takes effect immediately, including mid-transfer.
//   Read data returned after reset is discarded.
//  States: IDLE -> RUN on init. RUN -> DRAIN when issued==len. DRAIN -> DONE when all data arrived, FIFO empty
//   and last sample accepted. DONE (done=1, one cycle) -> IDLE.
//  init with load_len==0: IDLE -> DONE directly; no reads, no stream.
//  init while busy is ignored. base_addr/load_sector/load_len/compress/max are latched on accepted init.
//  Issue: avm_read=1 in RUN when issued<len and (inflight+fifo_count)<FIFO_DEPTH.
//   A read is accepted when avm_read & !avm_waitrequest. Address/read are held stable while waitrequest.
//   First avm_read occurs in the cycle after init (latency 1).
//  Address of word i = base + (sector<<(SECTOR_LOG2+2)) + 4*i, 32-bit wrap. inflight: +1 on accept, -1 on readdatavalid.
//   Simultaneous +1/-1 leaves it unchanged.
//  readdatavalid pushes the word into the FIFO; it never overflows, by the issue rule.
//  Unpack: compress=0 -> sample = word[23:0]. compress=1 -> sext(word[15:0]), then sext(word[31:16]).
//   The word is popped after its last sample is accepted.
//  Clamp (max!=0, signed compare): s>max -> max; s<-max -> -max. Otherwise pass through.
//  Stream: out_data and out_last stay stable while out_valid & !out_ready. out_valid never drops without a handshake.
//  out_last=1 on sample len-1 (compress=0) or 2*len-1 (compress=1).
//  Total samples = len or 2*len. busy=1 in RUN/DRAIN/DONE.
// TESTING
//  1 len=4, sector=1, base=0x1000, SECTOR_LOG2=8, no stall -> reads 0x1400,0x1404,0x1408,0x140C;
//    4 samples, last on 4th, done 1 pulse
//  2 compress=1, word 0xFFFE0003 -> samples 0x000003 then 0xFFFFFE
//  3 max=100, words 500, -500 (0xFFFE0C), 7 -> out 100, -100, 7
//  4 out_ready=0 for 50 cycles, len=20 -> issue stops at FIFO_DEPTH words; no data lost; order intact
//  5 random waitrequest and readdatavalid delays, len=64 -> address stable under stall; inflight<=FIFO_DEPTH; all 64 in order
//  6 init len=0 -> done next cycle, avm_read never asserted.
//    rst low mid-RUN -> outputs 0 immediately; stale readdatavalid ignored

Source files
------------

// File: rtl/ai_sector_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ai_sector_loader
//  Description : Reads a stored reference pattern through an Avalon-MM
//                pipelined read master, unpacks 32-bit words into signed
//                24-bit samples (optional 2x int16 packing), clamps them to
//                +/-max and streams them out over valid/ready with last.
//  Revision    : 1.0  initial release
// ============================================================================
module ai_sector_loader #(
  parameter int SECTOR_LOG2 = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [31:0] base_addr,
  input  logic [15:0] load_sector,
  input  logic [15:0] load_len,
  input  logic        compress,
  input  logic [23:0] max,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       len_q;
  logic [15:0]       issued;
  logic              compress_q;
  logic [23:0]       max_q;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic              half;
  logic [16:0]       sample_cnt;

  logic              accept;
  logic              push;
  logic              fire;
  logic              pop;
  logic              can_issue;
  logic [15:0]       issued_after;
  logic [CNT_W:0]    occ_next;
  logic [16:0]       total;
  logic [31:0]       head;
  logic [31:0]       start_addr;
  logic signed [23:0] raw;
  logic signed [23:0] clamped;
  logic signed [23:0] max_s;
  logic signed [23:0] neg_max;

  assign accept       = avm_read & ~avm_waitrequest;
  // Data returning with no read outstanding (e.g. after a reset) is dropped.
  assign push         = avm_readdatavalid & (inflight != '0);
  assign out_valid    = (fifo_count != '0);
  assign fire         = out_valid & out_ready;
  // A word leaves the buffer only once its final sample has been taken.
  assign pop          = fire & (~compress_q | half);
  assign issued_after = issued + 16'(accept);
  // Occupancy counts reads in flight as reserved slots, so the buffer can never overflow.
  assign occ_next     = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count)
                      + (CNT_W+1)'(accept) - (CNT_W+1)'(pop);
  assign can_issue    = (issued_after < len_q) && (occ_next < DEPTH_OCC);
  assign total        = compress_q ? {len_q, 1'b0} : {1'b0, len_q};
  assign head         = fifo_mem[rd_ptr];
  assign start_addr   = base_addr + (32'(load_sector) << (SECTOR_LOG2 + 2));

  // Unpack the head word into the current sample and clamp it to +/-max.
  always_comb begin
    raw = head[23:0];
    if (compress_q) begin
      raw = half ? {{8{head[31]}}, head[31:16]} : {{8{head[15]}}, head[15:0]};
    end
    max_s   = $signed(max_q);
    neg_max = -max_s;
    clamped = raw;
    if (max_q != 24'd0) begin
      if (raw > max_s) begin
        clamped = max_s;
      end else if (raw < neg_max) begin
        clamped = neg_max;
      end
    end
  end

  assign out_data = out_valid ? $unsigned(clamped) : 24'd0;
  assign out_last = out_valid & (sample_cnt == (total - 17'd1));

  // Word buffer storage; contents are only meaningful below fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= avm_readdata;
    end
  end

  // Control: state machine, read issue, in-flight/buffer accounting, stream position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      issued      <= '0;
      compress_q  <= 1'b0;
      max_q       <= '0;
      inflight    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      half        <= 1'b0;
      sample_cnt  <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      inflight   <= inflight + CNT_W'(accept) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr     <= wr_ptr + PTR_W'(push);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      if (fire) begin
        sample_cnt <= sample_cnt + 17'd1;
        if (compress_q) begin
          half <= ~half;
        end
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (init) begin
            len_q       <= load_len;
            compress_q  <= compress;
            max_q       <= max;
            issued      <= '0;
            sample_cnt  <= '0;
            half        <= 1'b0;
            avm_address <= start_addr;
            busy        <= 1'b1;
            if (load_len == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_RUN;
              avm_read <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            issued      <= issued_after;
            avm_address <= avm_address + 32'd4;
          end
          // A stalled request keeps its read and address until accepted.
          if (!(avm_read && avm_waitrequest)) begin
            avm_read <= can_issue;
          end
          if (issued == len_q) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0) && (sample_cnt == total)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
